spi_byte_shifter: RTL and testbench

Byte-serial SPI shift engine that sits directly downstream of the AHB SPI register block. It takes the write-data word and the byte count from that block, shifts bytes out on MOSI MSB-first, and captures MISO into a read-data word. It reports a running count of completed bytes back to the register block, which uses that count to drive its RDATA_READY and WDATA_FINISHED status flags.

---
 rtl/spi_byte_shifter_if.sv | 49 ++++
 rtl/spi_byte_shifter.sv | 193 +++++++++++++++++++
 tb/tb_spi_byte_shifter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_shifter_if.sv
// Signal bundle between the SPI register block (master) and spi_byte_shifter (slave), including the SPI pins.
// cpol_i/cpha_i exist only when SPI_CPOL_CPHA_EN is defined.
interface spi_byte_shifter_if;
   logic        enable_i;
   logic [31:0] spi_write_data_i;
   logic [2:0]  spi_write_data_bytes_valid_i;
   logic        reset_fill_level_i;
   logic        spi_miso_i;
   logic        spi_mosi_o;
   logic        spi_clk_o;
   logic [31:0] spi_read_data_o;
   logic [2:0]  spi_read_data_bytes_valid_o;
`ifdef SPI_CPOL_CPHA_EN
   logic        cpol_i;
   logic        cpha_i;
`endif

   modport slave (
`ifdef SPI_CPOL_CPHA_EN
      input  cpol_i,
      input  cpha_i,
`endif
      input  enable_i,
      input  spi_write_data_i,
      input  spi_write_data_bytes_valid_i,
      input  reset_fill_level_i,
      input  spi_miso_i,
      output spi_mosi_o,
      output spi_clk_o,
      output spi_read_data_o,
      output spi_read_data_bytes_valid_o
   );

   modport master (
`ifdef SPI_CPOL_CPHA_EN
      output cpol_i,
      output cpha_i,
`endif
      output enable_i,
      output spi_write_data_i,
      output spi_write_data_bytes_valid_i,
      output reset_fill_level_i,
      output spi_miso_i,
      input  spi_mosi_o,
      input  spi_clk_o,
      input  spi_read_data_o,
      input  spi_read_data_bytes_valid_o
   );
endinterface

// File: rtl/spi_byte_shifter.sv
// Byte-serial SPI shift engine: MSB-first TX from the write word, RX packed into the read word, running byte count.
// Optional macro SPI_CPOL_CPHA_EN adds cpol_i/cpha_i; without it the engine is fixed at SPI mode 0.
module spi_byte_shifter #(
   parameter int unsigned CLK_DIV = 2
) (
   input logic               clk_i,
   input logic               rstn_i,
   spi_byte_shifter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      GAP  = 2'd3
   } state_e;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_e      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  sent_cnt_q, sent_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rx_q, rx_d;
   logic        mosi_q, mosi_d;
   logic        spi_clk_q, spi_clk_d;
   logic [31:0] rdata_q, rdata_d;
   logic [2:0]  fill_q, fill_d;
   logic        cpol_q, cpol_d;
   logic        cpha_q, cpha_d;

   logic [2:0]  valid_s;
   logic [4:0]  byte_base_s;
   logic [7:0]  tx_byte_s;
   logic [7:0]  rx_byte_s;
   logic        cpol_in_s;
   logic        cpha_in_s;

`ifdef SPI_CPOL_CPHA_EN
   assign cpol_in_s = bus.cpol_i;
   assign cpha_in_s = bus.cpha_i;
`else
   assign cpol_in_s = 1'b0;
   assign cpha_in_s = 1'b0;
`endif

   assign valid_s     = (bus.spi_write_data_bytes_valid_i > 3'd4) ? 3'd0 : bus.spi_write_data_bytes_valid_i;
   assign byte_base_s = {sent_cnt_q[1:0], 3'b000};
   assign tx_byte_s   = bus.spi_write_data_i[byte_base_s +: 8];

   assign bus.spi_mosi_o                  = mosi_q;
   assign bus.spi_clk_o                   = spi_clk_q;
   assign bus.spi_read_data_o             = rdata_q;
   assign bus.spi_read_data_bytes_valid_o = fill_q;

   // Next-state and output computation for the byte shifter FSM.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_cnt_d  = bit_cnt_q;
      sent_cnt_d = sent_cnt_q;
      shift_d    = shift_q;
      rx_d       = rx_q;
      mosi_d     = mosi_q;
      rdata_d    = rdata_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      rx_byte_s  = rx_q;
      fill_d     = bus.reset_fill_level_i ? 3'd0 : fill_q;

      // Losing enable mid-byte drops the partial byte and the whole transfer.
      if (!bus.enable_i && (state_q == LOW || state_q == HIGH)) begin
         state_d    = IDLE;
         div_d      = 8'd0;
         bit_cnt_d  = 3'd0;
         sent_cnt_d = 3'd0;
         mosi_d     = 1'b0;
         fill_d     = 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               mosi_d = 1'b0;
               div_d  = 8'd0;
               cpol_d = cpol_in_s;
               cpha_d = cpha_in_s;
               if (valid_s == 3'd0) begin
                  sent_cnt_d = 3'd0;
               end else if (bus.enable_i && (sent_cnt_q < valid_s)) begin
                  state_d   = LOW;
                  shift_d   = tx_byte_s;
                  bit_cnt_d = 3'd0;
                  rx_d      = 8'd0;
                  mosi_d    = cpha_in_s ? 1'b0 : tx_byte_s[7];
               end else begin
                  state_d = IDLE;
               end
            end
            LOW: begin
               if (div_q == DIV_LAST) begin
                  div_d   = 8'd0;
                  state_d = HIGH;
                  // Leading edge: shift out (CPHA=1) or sample (CPHA=0).
                  if (cpha_q) begin
                     mosi_d  = shift_q[7];
                     shift_d = {shift_q[6:0], 1'b0};
                  end else begin
                     rx_d = {rx_q[6:0], bus.spi_miso_i};
                  end
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
            HIGH: begin
               rx_byte_s = cpha_q ? {rx_q[6:0], bus.spi_miso_i} : rx_q;
               if (div_q == DIV_LAST) begin
                  div_d = 8'd0;
                  rx_d  = rx_byte_s;
                  if (bit_cnt_q != 3'd7) begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                     state_d   = LOW;
                     if (!cpha_q) begin
                        mosi_d  = shift_q[6];
                        shift_d = {shift_q[6:0], 1'b0};
                     end else begin
                        shift_d = shift_q;
                     end
                  end else begin
                     state_d                   = GAP;
                     rdata_d[byte_base_s +: 8] = rx_byte_s;
                     sent_cnt_d                = sent_cnt_q + 3'd1;
                     // A completing byte overrides a same-cycle fill-level clear.
                     if (bus.reset_fill_level_i) begin
                        fill_d = 3'd1;
                     end else if (fill_q == 3'd4) begin
                        fill_d = 3'd4;
                     end else begin
                        fill_d = fill_q + 3'd1;
                     end
                  end
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
            GAP: begin
               state_d = IDLE;
               mosi_d  = 1'b0;
               if (valid_s == 3'd0) begin
                  sent_cnt_d = 3'd0;
               end else begin
                  sent_cnt_d = sent_cnt_q;
               end
            end
            default: begin
               state_d = IDLE;
               mosi_d  = 1'b0;
            end
         endcase
      end

      spi_clk_d = (state_d == HIGH) ^ cpol_d;
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         div_q      <= 8'd0;
         bit_cnt_q  <= 3'd0;
         sent_cnt_q <= 3'd0;
         shift_q    <= 8'd0;
         rx_q       <= 8'd0;
         mosi_q     <= 1'b0;
         spi_clk_q  <= 1'b0;
         rdata_q    <= 32'd0;
         fill_q     <= 3'd0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_cnt_q  <= bit_cnt_d;
         sent_cnt_q <= sent_cnt_d;
         shift_q    <= shift_d;
         rx_q       <= rx_d;
         mosi_q     <= mosi_d;
         spi_clk_q  <= spi_clk_d;
         rdata_q    <= rdata_d;
         fill_q     <= fill_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
      end
   end
endmodule

// File: tb/tb_spi_byte_shifter.sv
// Scoreboard bench for spi_byte_shifter at CLK_DIV=2 with MISO looped back to MOSI.
// Stimulus pushes expected MOSI bits and byte-completion events; a negedge monitor pops and compares.
module tb_spi_byte_shifter;
   localparam int CLK_DIV = 2;

   logic clk = 1'b0;
   logic rstn;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   typedef struct {
      logic [2:0]  cnt;
      logic [31:0] rd;
      int          at;
   } exp_t;

   exp_t        sb_q[$];
   logic        bit_q[$];
   logic [31:0] exp_rd  = 32'h0;
   logic [2:0]  exp_cnt = 3'd0;
   int          t0;

   spi_byte_shifter_if bus();

   spi_byte_shifter #(.CLK_DIV(CLK_DIV)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus.slave)
   );

   assign bus.spi_miso_i = bus.spi_mosi_o;

`ifdef SPI_CPOL_CPHA_EN
   initial begin
      bus.cpol_i = 1'b0;
      bus.cpha_i = 1'b0;
   end
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_byte(input int idx, input logic [7:0] b, input int at);
      for (int i = 7; i >= 0; i--) bit_q.push_back(b[i]);
      exp_rd[idx*8 +: 8] = b;
      exp_cnt = (exp_cnt == 3'd4) ? 3'd4 : exp_cnt + 3'd1;
      sb_q.push_back('{exp_cnt, exp_rd, at});
   endtask

   task automatic expect_zero();
      if (exp_cnt != 3'd0) sb_q.push_back('{3'd0, exp_rd, -1});
      exp_cnt = 3'd0;
   endtask

   task automatic clear_engine();
      bus.spi_write_data_bytes_valid_i = 3'd0;
      bus.reset_fill_level_i = 1'b1;
      expect_zero();
      step(1);
      bus.reset_fill_level_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb_q.size() != 0 || bit_q.size() != 0) && n < 400) begin
         step(1);
         n++;
      end
      check({name, "_drained"}, 32'(sb_q.size() + bit_q.size()), 32'd0);
      sb_q.delete();
      bit_q.delete();
      step(10);
      check({name, "_sclk_idle"}, 32'(bus.spi_clk_o), 32'd0);
   endtask

   // Monitor: every SPI rising edge consumes one MOSI bit, every count change consumes one completion event.
   initial begin : monitor
      logic [2:0] prev_cnt;
      logic       prev_sclk;
      exp_t       e;
      prev_cnt  = 3'd0;
      prev_sclk = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.spi_clk_o === 1'b1 && prev_sclk === 1'b0) begin
            if (bit_q.size() == 0) check("extra_sclk_edge", 32'd1, 32'd0);
            else check("mosi_bit", 32'(bus.spi_mosi_o), 32'(bit_q.pop_front()));
         end
         if (bus.spi_read_data_bytes_valid_o !== prev_cnt) begin
            if (sb_q.size() == 0) begin
               check("unexpected_count_change", 32'(bus.spi_read_data_bytes_valid_o), 32'(prev_cnt));
            end else begin
               e = sb_q.pop_front();
               check("bytes_valid", 32'(bus.spi_read_data_bytes_valid_o), 32'(e.cnt));
               check("read_data", bus.spi_read_data_o, e.rd);
               if (e.at >= 0) check("done_cycle", 32'(cyc), 32'(e.at));
            end
         end
         prev_cnt  = bus.spi_read_data_bytes_valid_o;
         prev_sclk = bus.spi_clk_o;
      end
   end

   initial begin
      rstn = 1'b0;
      bus.enable_i = 1'b0;
      bus.spi_write_data_i = 32'h0;
      bus.spi_write_data_bytes_valid_i = 3'd0;
      bus.reset_fill_level_i = 1'b0;
      #3;
      check("reset_sclk", 32'(bus.spi_clk_o), 32'd0);
      check("reset_mosi", 32'(bus.spi_mosi_o), 32'd0);
      check("reset_rdata", bus.spi_read_data_o, 32'h0);
      check("reset_count", 32'(bus.spi_read_data_bytes_valid_o), 32'd0);
      step(2);
      rstn = 1'b1;
      step(2);

      // Single byte 0xA5; count must appear on the 33rd edge after the request is applied.
      bus.spi_write_data_i = 32'h000000A5;
      bus.enable_i = 1'b1;
      bus.spi_write_data_bytes_valid_i = 3'd1;
      t0 = cyc;
      expect_byte(0, 8'hA5, t0 + 33);
      drain("single");

      // Four bytes, 34-cycle spacing.
      clear_engine();
      bus.spi_write_data_i = 32'hDEADBEEF;
      t0 = cyc;
      bus.spi_write_data_bytes_valid_i = 3'd4;
      expect_byte(0, 8'hEF, t0 + 33);
      expect_byte(1, 8'hBE, t0 + 67);
      expect_byte(2, 8'hAD, t0 + 101);
      expect_byte(3, 8'hDE, t0 + 135);
      drain("four");
      check("four_rdata", bus.spi_read_data_o, 32'hDEADBEEF);

      // Fill-level clear between byte 2 and byte 3.
      clear_engine();
      bus.spi_write_data_i = 32'h12345678;
      t0 = cyc;
      bus.spi_write_data_bytes_valid_i = 3'd4;
      expect_byte(0, 8'h78, t0 + 33);
      expect_byte(1, 8'h56, t0 + 67);
      expect_zero();
      expect_byte(2, 8'h34, t0 + 101);
      expect_byte(3, 8'h12, t0 + 135);
      while (cyc < t0 + 80) step(1);
      bus.reset_fill_level_i = 1'b1;
      step(1);
      bus.reset_fill_level_i = 1'b0;
      drain("fill_clear");

      // Abort during bit 4 (fifth bit) of byte 0x3C, then restart.
      clear_engine();
      bus.spi_write_data_i = 32'h0000003C;
      t0 = cyc;
      bus.spi_write_data_bytes_valid_i = 3'd1;
      bit_q.push_back(1'b0);
      bit_q.push_back(1'b0);
      bit_q.push_back(1'b1);
      bit_q.push_back(1'b1);
      bit_q.push_back(1'b1);
      while (cyc < t0 + 20) step(1);
      bus.enable_i = 1'b0;
      step(1);
      check("abort_bits_seen", 32'(bit_q.size()), 32'd0);
      check("abort_sclk", 32'(bus.spi_clk_o), 32'd0);
      check("abort_mosi", 32'(bus.spi_mosi_o), 32'd0);
      check("abort_count", 32'(bus.spi_read_data_bytes_valid_o), 32'd0);
      check("abort_rdata", bus.spi_read_data_o, 32'h12345678);
      bus.enable_i = 1'b1;
      t0 = cyc;
      expect_byte(0, 8'h3C, t0 + 33);
      drain("restart");

      // valid=5 is treated as zero.
      clear_engine();
      bus.spi_write_data_i = 32'h000000C3;
      bus.spi_write_data_bytes_valid_i = 3'd5;
      step(40);
      check("valid5_count", 32'(bus.spi_read_data_bytes_valid_o), 32'd0);
      check("valid5_sclk", 32'(bus.spi_clk_o), 32'd0);

      // valid 1 -> 0 -> 1 sends the byte twice.
      t0 = cyc;
      bus.spi_write_data_bytes_valid_i = 3'd1;
      expect_byte(0, 8'hC3, t0 + 33);
      drain("resend_a");
      bus.spi_write_data_bytes_valid_i = 3'd0;
      step(1);
      t0 = cyc;
      bus.spi_write_data_bytes_valid_i = 3'd1;
      expect_byte(0, 8'hC3, t0 + 33);
      drain("resend_b");

      // Asynchronous reset in the middle of a byte.
      bus.spi_write_data_bytes_valid_i = 3'd0;
      step(1);
      bus.spi_write_data_i = 32'h000000FF;
      t0 = cyc;
      bus.spi_write_data_bytes_valid_i = 3'd1;
      bit_q.push_back(1'b1);
      while (cyc < t0 + 4) step(1);
      check("prereset_sclk", 32'(bus.spi_clk_o), 32'd1);
      exp_rd = 32'h0;
      expect_zero();
      #2;
      rstn = 1'b0;
      #1;
      check("areset_sclk", 32'(bus.spi_clk_o), 32'd0);
      check("areset_mosi", 32'(bus.spi_mosi_o), 32'd0);
      check("areset_rdata", bus.spi_read_data_o, 32'h0);
      check("areset_count", 32'(bus.spi_read_data_bytes_valid_o), 32'd0);
      step(2);
      rstn = 1'b1;
      step(2);
      check("areset_sb_drained", 32'(sb_q.size() + bit_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
